spi_cmd_decoder: RTL and testbench

Downstream consumer of the SPI slave. Takes each completed 64-bit frame (RECEIVED qualified by RXED), decodes it as a register-access command, and executes it against a local configuration register bank. Builds the 64-bit response word driven back into the SPI slave's TO_SEND, which shifts it out during the next frame (full-duplex, one-frame response latency). Register contents are exported flat to drive chip configuration.

---
 rtl/spi_cmd_pkg.sv | 51 +++++
 rtl/spi_cmd_decoder_if.sv | 12 +
 rtl/spi_evt_sync.sv | 28 ++
 rtl/spi_cmd_decoder.sv | 170 +++++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared constants and types for the SPI command decoder: opcodes, status
// codes, frame field positions, FSM state encoding and the response layout.
// The optional parity check is enabled with the CMD_PARITY_EN macro.
package spi_cmd_pkg;

   localparam int FRAME_LEN  = 64;
   localparam int REG_DATA_W = 32;
   localparam int REG_COUNT  = 16;
   localparam logic [31:0] CHIP_ID_DEFAULT = 32'h5E1C_2024;

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_WRITE = 8'h01;
   localparam logic [7:0] OP_READ  = 8'h02;

   localparam logic [7:0] ST_OK      = 8'h00;
   localparam logic [7:0] ST_BADOP   = 8'hE1;
   localparam logic [7:0] ST_BADADDR = 8'hE2;
   localparam logic [7:0] ST_RO      = 8'hE3;
   localparam logic [7:0] ST_PARITY  = 8'hE4;

   localparam int OPC_MSB    = 63;
   localparam int OPC_LSB    = 56;
   localparam int ADDR_MSB   = 55;
   localparam int ADDR_LSB   = 48;
   localparam int RSV_MSB    = 47;
   localparam int RSV_LSB    = 32;
   localparam int PARITY_BIT = 47;
   localparam int DATA_MSB   = 31;
   localparam int DATA_LSB   = 0;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_CAPTURE = 2'd1;
   localparam logic [1:0] S_EXEC    = 2'd2;
   localparam logic [1:0] S_RESP    = 2'd3;

   typedef struct packed {
      logic [7:0]  status;
      logic [7:0]  addr;
      logic [15:0] frame_cnt;
      logic [31:0] rdata;
   } resp_t;

   // Even parity over opcode/addr, the parity bit itself and the data word:
   // a correct frame XORs to zero.
   function automatic logic frame_parity(input logic [15:0] header,
                                         input logic        parity_bit,
                                         input logic [31:0] data);
      return ^{header, parity_bit, data};
   endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Link between the SPI slave and the command decoder: the received frame,
// its frame-complete level and the response word for the next frame.
interface spi_cmd_decoder_if #(
   parameter int LENGTH = 64
);
   logic [LENGTH-1:0] RECEIVED;
   logic              RXED;
   logic [LENGTH-1:0] TO_SEND;

   modport master (output RECEIVED, output RXED, input TO_SEND);
   modport slave  (input RECEIVED, input RXED, output TO_SEND);
endinterface

// File: rtl/spi_evt_sync.sv
// Two-flop synchronizer plus rising-edge detector for a level coming from
// another clock domain (RXED here, TXED elsewhere).
module spi_evt_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic evt
);
   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Shift the async level through two sync flops and keep one more for the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign evt = sync_q & ~prev_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: decodes each completed frame as a register command,
// executes it against a local register bank and builds the response shifted
// out on the next frame. Macro CMD_PARITY_EN enables the frame parity check
// on bit 47; without it bit 47 is an ordinary ignored reserved bit.
module spi_cmd_decoder
   import spi_cmd_pkg::*;
#(
   parameter int                LENGTH   = FRAME_LEN,
   parameter int                DATA_W   = REG_DATA_W,
   parameter int                NUM_REGS = REG_COUNT,
   parameter logic [DATA_W-1:0] CHIP_ID  = CHIP_ID_DEFAULT
) (
   input  logic                       CLK,
   input  logic                       RESET,
   spi_cmd_decoder_if.slave           bus,
   output logic [NUM_REGS*DATA_W-1:0] CFG_REGS,
   output logic                       WR_STROBE,
   output logic [7:0]                 WR_ADDR,
   output logic                       OVERRUN
);
   localparam int AW = $clog2(NUM_REGS);

   logic              rx_evt;
   logic [1:0]        state;
   logic [7:0]        opcode_q;
   logic [7:0]        addr_q;
   logic [DATA_W-1:0] data_q;
   logic [15:0]       frame_cnt;
   logic              frame_bad_parity;
   logic [DATA_W-1:0] bank [NUM_REGS];
   logic [7:0]        exec_status;
   logic [DATA_W-1:0] exec_rdata;
   logic              exec_write;
   resp_t             exec_resp;
   logic [LENGTH-1:0] to_send_q;
   logic              unused_rsv;

   spi_evt_sync u_rx_sync (
      .clk      (CLK),
      .rst      (RESET),
      .async_in (bus.RXED),
      .evt      (rx_evt)
   );

   // The reserved field carries no command information.
   assign unused_rsv = ^bus.RECEIVED[RSV_MSB:RSV_LSB];

   // Sequencer: one cycle each in capture, execute and response after an event.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE:    if (rx_evt) state <= S_CAPTURE;
            S_CAPTURE: state <= S_EXEC;
            S_EXEC:    state <= S_RESP;
            default:   state <= S_IDLE;
         endcase
      end
   end

   // A frame arriving while a command is in flight is dropped and flagged until reset.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         OVERRUN <= 1'b0;
      end else if (rx_evt && state != S_IDLE) begin
         OVERRUN <= 1'b1;
      end
   end

   // Latch the command fields once, so RECEIVED may change after capture.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         opcode_q <= '0;
         addr_q   <= '0;
         data_q   <= '0;
      end else if (state == S_CAPTURE) begin
         opcode_q <= bus.RECEIVED[OPC_MSB:OPC_LSB];
         addr_q   <= bus.RECEIVED[ADDR_MSB:ADDR_LSB];
         data_q   <= bus.RECEIVED[DATA_MSB:DATA_LSB];
      end
   end

   // Count every captured frame; the counter wraps naturally at 16 bits.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         frame_cnt <= '0;
      end else if (state == S_CAPTURE) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end

`ifdef CMD_PARITY_EN
   logic parity_err_q;

   // Evaluate frame parity at capture so execution sees a registered flag.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         parity_err_q <= 1'b0;
      end else if (state == S_CAPTURE) begin
         parity_err_q <= frame_parity(bus.RECEIVED[OPC_MSB:ADDR_LSB],
                                      bus.RECEIVED[PARITY_BIT],
                                      bus.RECEIVED[DATA_MSB:DATA_LSB]);
      end
   end

   assign frame_bad_parity = parity_err_q;
`else
   assign frame_bad_parity = 1'b0;
`endif

   // Validate the captured command in priority order and pick the read-back data.
   always_comb begin
      exec_status = ST_OK;
      exec_rdata  = '0;
      exec_write  = 1'b0;
      if (frame_bad_parity) begin
         exec_status = ST_PARITY;
      end else if (opcode_q != OP_NOP && opcode_q != OP_WRITE && opcode_q != OP_READ) begin
         exec_status = ST_BADOP;
      end else if (opcode_q != OP_NOP && addr_q >= 8'(NUM_REGS)) begin
         exec_status = ST_BADADDR;
      end else if (opcode_q == OP_WRITE && addr_q == 8'd0) begin
         exec_status = ST_RO;
      end else if (opcode_q == OP_WRITE) begin
         exec_write = 1'b1;
         exec_rdata = data_q;
      end else if (opcode_q == OP_READ) begin
         exec_rdata = bank[addr_q[AW-1:0]];
      end
   end

   assign exec_resp = {exec_status, addr_q, frame_cnt, exec_rdata};

   // Register bank: register 0 holds the chip id and is never written.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            bank[i] <= (i == 0) ? CHIP_ID : '0;
         end
      end else if (state == S_EXEC && exec_write) begin
         bank[addr_q[AW-1:0]] <= data_q;
      end
   end

   // The response, write strobe and write address all become visible in the response cycle.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         to_send_q <= '0;
         WR_STROBE <= 1'b0;
         WR_ADDR   <= '0;
      end else begin
         WR_STROBE <= 1'b0;
         if (state == S_EXEC) begin
            to_send_q <= exec_resp;
            if (exec_write) begin
               WR_STROBE <= 1'b1;
               WR_ADDR   <= addr_q;
            end
         end
      end
   end

   assign bus.TO_SEND = to_send_q;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign CFG_REGS[g*DATA_W +: DATA_W] = bank[g];
   end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: directed scenarios followed by
// random commands, compared against a register-bank model of the command set.
// Build with CMD_PARITY_EN defined to also exercise the frame parity check.
module tb_spi_cmd_decoder;

   localparam logic [31:0] CHIP_ID = 32'h5E1C_2024;

   logic         clk = 1'b0;
   logic         rst;
   logic [511:0] cfg_regs;
   logic         wr_strobe;
   logic [7:0]   wr_addr;
   logic         overrun;

   spi_cmd_decoder_if #(.LENGTH(64)) bus ();

   spi_cmd_decoder dut (
      .CLK       (clk),
      .RESET     (rst),
      .bus       (bus),
      .CFG_REGS  (cfg_regs),
      .WR_STROBE (wr_strobe),
      .WR_ADDR   (wr_addr),
      .OVERRUN   (overrun)
   );

   // 50 MHz clock.
   always #10 clk = ~clk;

   int compared = 0;
   int mismatched = 0;

   logic [31:0] m_regs [16];
   logic [15:0] m_cnt;
   logic [63:0] m_to_send;
   logic [7:0]  m_wr_addr;
   logic        m_overrun;

   // Guard against a hung run.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = (i == 0) ? CHIP_ID : 32'h0;
      m_cnt     = 16'h0;
      m_to_send = 64'h0;
      m_wr_addr = 8'h0;
      m_overrun = 1'b0;
   endtask

   function automatic logic [511:0] model_bank();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = m_regs[i];
      return v;
   endfunction

   // Sets bit 47 so the frame has even parity (only in the parity build).
   function automatic logic [63:0] with_parity(input logic [63:0] f);
      logic [63:0] r;
      r = f;
`ifdef CMD_PARITY_EN
      r[47] = (($countones({r[63:48], r[31:0]}) % 2) == 1);
`endif
      return r;
   endfunction

   // Reference behaviour of one accepted command, straight from the command rules.
   task automatic model_command(input logic [63:0] frame, output logic [63:0] resp,
                                output bit wrote);
      logic [7:0]  op;
      logic [7:0]  a;
      logic [7:0]  status;
      logic [31:0] d;
      logic [31:0] rdata;
      bit          parity_bad;
      op = frame[63:56];
      a  = frame[55:48];
      d  = frame[31:0];
      status = 8'h00;
      rdata  = 32'h0;
      wrote  = 1'b0;
      parity_bad = 1'b0;
`ifdef CMD_PARITY_EN
      parity_bad = (($countones({frame[63:47], frame[31:0]}) % 2) != 0);
`endif
      m_cnt = m_cnt + 16'd1;
      if (parity_bad) status = 8'hE4;
      else if (op > 8'h02) status = 8'hE1;
      else if (op != 8'h00 && a >= 8'd16) status = 8'hE2;
      else if (op == 8'h01 && a == 8'd0) status = 8'hE3;
      else if (op == 8'h01) begin
         m_regs[a[3:0]] = d;
         rdata = d;
         wrote = 1'b1;
         m_wr_addr = a;
      end else if (op == 8'h02) begin
         rdata = m_regs[a[3:0]];
      end
      resp = {status, a, m_cnt, rdata};
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.RXED = 1'b0;
      bus.RECEIVED = 64'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   // Sends one frame (called on a falling edge) and checks response timing and side effects.
   // RXED rises here; two sync edges later the event is seen, and the response
   // is expected three cycles after that, i.e. visible after the 5th rising edge.
   task automatic apply_stimulus(input string tag, input logic [63:0] frame);
      logic [63:0] exp_resp;
      logic [63:0] old_resp;
      bit          exp_wr;
      int          strobes;
      old_resp = m_to_send;
      model_command(frame, exp_resp, exp_wr);
      bus.RECEIVED = frame;
      bus.RXED = 1'b1;
      strobes = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (wr_strobe === 1'b1) strobes++;
         if (k == 4) check_output({tag, " hold"}, bus.TO_SEND, old_resp);
         if (k == 5) begin
            check_output({tag, " resp"}, bus.TO_SEND, exp_resp);
            bus.RXED = 1'b0;
         end
      end
      m_to_send = exp_resp;
      check_output({tag, " strobes"}, strobes, exp_wr ? 1 : 0);
      check_output({tag, " wr_addr"}, wr_addr, m_wr_addr);
      check_output({tag, " bank"}, cfg_regs, model_bank());
      check_output({tag, " overrun"}, overrun, m_overrun);
   endtask

   initial begin
      logic [63:0] f;
      logic [63:0] exp_resp;
      bit          exp_wr;
      int          strobes;
      int          pick;

      rst = 1'b0;
      bus.RXED = 1'b0;
      bus.RECEIVED = 64'h0;
      @(negedge clk);
      do_reset();

      $display("[TB] reset state");
      check_output("reset to_send", bus.TO_SEND, 64'h0);
      check_output("reset bank", cfg_regs, model_bank());
      check_output("reset reg0", cfg_regs[31:0], 32'h5E1C_2024);
      check_output("reset wr_strobe", wr_strobe, 1'b0);
      check_output("reset wr_addr", wr_addr, 8'h0);
      check_output("reset overrun", overrun, 1'b0);

      $display("[TB] read chip id");
      apply_stimulus("read0", with_parity(64'h0200_0000_0000_0000));
      check_output("read0 literal", bus.TO_SEND, 64'h0000_0001_5E1C_2024);

      $display("[TB] write then read back");
      do_reset();
      apply_stimulus("write5", with_parity(64'h0105_0000_DEAD_BEEF));
      check_output("write5 literal", bus.TO_SEND, 64'h0005_0001_DEAD_BEEF);
      check_output("write5 wr_addr lit", wr_addr, 8'h05);
      check_output("write5 reg5 lit", cfg_regs[5*32 +: 32], 32'hDEAD_BEEF);
      apply_stimulus("read5", with_parity(64'h0205_0000_0000_0000));
      check_output("read5 literal", bus.TO_SEND, 64'h0005_0002_DEAD_BEEF);

      $display("[TB] error cases");
      apply_stimulus("badop", with_parity(64'h7F03_0000_1111_1111));
      check_output("badop status", bus.TO_SEND[63:56], 8'hE1);
      check_output("badop rdata", bus.TO_SEND[31:0], 32'h0);
      apply_stimulus("badaddr", with_parity(64'h0210_0000_0000_0000));
      check_output("badaddr status", bus.TO_SEND[63:56], 8'hE2);
      apply_stimulus("ro", with_parity(64'h0100_0000_BAD0_BAD0));
      check_output("ro status", bus.TO_SEND[63:56], 8'hE3);
      check_output("ro rdata", bus.TO_SEND[31:0], 32'h0);

      $display("[TB] second frame while busy");
      f = with_parity(64'h0109_0000_1234_5678);
      model_command(f, exp_resp, exp_wr);
      bus.RECEIVED = f;
      bus.RXED = 1'b1;
      strobes = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (wr_strobe === 1'b1) strobes++;
         if (k == 1) bus.RXED = 1'b0;
         if (k == 2) bus.RXED = 1'b1;
      end
      bus.RXED = 1'b0;
      repeat (3) @(negedge clk);
      m_overrun = 1'b1;
      m_to_send = exp_resp;
      check_output("ovr resp", bus.TO_SEND, exp_resp);
      check_output("ovr strobes", strobes, 1);
      check_output("ovr flag", overrun, 1'b1);
      check_output("ovr bank", cfg_regs, model_bank());
      apply_stimulus("after_ovr", with_parity(64'h0209_0000_0000_0000));

      $display("[TB] reset during execute");
      bus.RECEIVED = with_parity(64'h0107_0000_CAFE_F00D);
      bus.RXED = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      bus.RXED = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (4) @(negedge clk);
      check_output("rstx bank", cfg_regs, model_bank());
      check_output("rstx reg7", cfg_regs[7*32 +: 32], 32'h0);
      check_output("rstx overrun", overrun, 1'b0);
      check_output("rstx to_send", bus.TO_SEND, 64'h0);
      check_output("rstx wr_addr", wr_addr, 8'h0);

      $display("[TB] frame counter wrap");
      apply_stimulus("pre_wrap", with_parity(64'h0202_0000_0000_0000));
      force dut.frame_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.frame_cnt;
      m_cnt = 16'hFFFF;
      apply_stimulus("wrap_nop", with_parity(64'h0003_0000_0000_0000));
      check_output("wrap cnt field", bus.TO_SEND[47:32], 16'h0000);

`ifdef CMD_PARITY_EN
      $display("[TB] parity check");
      f = with_parity(64'h0106_0000_A5A5_0F0F);
      f[47] = ~f[47];
      apply_stimulus("par_bad", f);
      check_output("par_bad status", bus.TO_SEND[63:56], 8'hE4);
      check_output("par_bad reg6", cfg_regs[6*32 +: 32], 32'h0);
      apply_stimulus("par_good", with_parity(64'h0106_0000_A5A5_0F0F));
      check_output("par_good status", bus.TO_SEND[63:56], 8'h00);
      check_output("par_good reg6", cfg_regs[6*32 +: 32], 32'hA5A5_0F0F);
`endif

      $display("[TB] random commands");
      for (int n = 0; n < 40; n++) begin
         pick = $urandom_range(0, 9);
         if (pick < 4) f[63:56] = 8'h01;
         else if (pick < 7) f[63:56] = 8'h02;
         else if (pick == 7) f[63:56] = 8'h00;
         else f[63:56] = 8'($urandom_range(3, 255));
         f[55:48] = 8'($urandom_range(0, 19));
         f[47:32] = 16'($urandom);
         f[31:0] = $urandom;
`ifdef CMD_PARITY_EN
         if ($urandom_range(0, 3) != 0) f = with_parity(f);
`endif
         apply_stimulus($sformatf("rand%0d", n), f);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
